// File: rtl/chain_test_ctrl.sv
// Delay-chain latency tester: flushes one of eight chains, injects a single pulse
// and counts cycles until it emerges, then reports pass/stuck/measured latency.
module chain_test_ctrl #(
    parameter int N         = 80,
    parameter int FLUSH_CYC = 96,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] chain_sel,
    input  logic [7:0] expected,
    input  logic [7:0] user_din,
    input  logic [7:0] chain_dout,
    output logic [7:0] chain_din,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       stuck,
    output logic [7:0] measured
);

    // state   | meaning
    // IDLE    | user_din bypassed to chain_din, waiting for start
    // FLUSH   | drive zeros for FLUSH_CYC cycles, then check for stuck-high
    // PULSE   | single-cycle one-hot on the selected chain input
    // MEASURE | count cycles until the pulse reaches the chain output
    // REPORT  | done pulse, results valid
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FLUSH   = 3'd1;
    localparam logic [2:0] S_PULSE   = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    localparam int         FW  = $clog2(FLUSH_CYC + 1);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    if (FLUSH_CYC <= N) begin : g_flush_chk
        $error("FLUSH_CYC must exceed the chain depth N");
    end
    if (TIMEOUT > 255 || TIMEOUT < 1) begin : g_tmo_chk
        $error("TIMEOUT must fit in 8 bits");
    end

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [2:0]    r_sel;
    logic [7:0]    r_exp;
    logic [7:0]    r_cnt;
    logic [FW-1:0] r_flush_cnt;
    logic [7:0]    r_chain_din;
    logic          r_pass;
    logic          r_stuck;
    logic [7:0]    r_measured;
    logic          w_sel_out;
    logic [7:0]    w_onehot;

    assign w_sel_out = chain_dout[r_sel];
    assign w_onehot  = 8'd1 << r_sel;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_FLUSH;
            S_FLUSH:   if (r_flush_cnt == '0) w_state_nxt = w_sel_out ? S_REPORT : S_PULSE;
            S_PULSE:   w_state_nxt = S_MEASURE;
            S_MEASURE: if (w_sel_out || r_cnt == TMO) w_state_nxt = S_REPORT;
            S_REPORT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_chain_din <= '0;
            r_pass      <= 1'b0;
            r_stuck     <= 1'b0;
            r_measured  <= '0;
        end else begin
            r_state <= w_state_nxt;

            // chain_din follows the state being entered so it lines up with that state
            case (w_state_nxt)
                S_IDLE:  r_chain_din <= user_din;
                S_PULSE: r_chain_din <= w_onehot;
                default: r_chain_din <= '0;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel       <= chain_sel;
                        r_exp       <= expected;
                        r_pass      <= 1'b0;
                        r_stuck     <= 1'b0;
                        r_measured  <= '0;
                        r_flush_cnt <= FW'(FLUSH_CYC - 1);
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt != '0) begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end else if (w_sel_out) begin
                        r_stuck    <= 1'b1;
                        r_pass     <= 1'b0;
                        r_measured <= '0;
                    end
                end
                S_PULSE: r_cnt <= 8'd1;
                S_MEASURE: begin
                    // detection is checked first so a hit at TIMEOUT still compares
                    if (w_sel_out) begin
                        r_measured <= r_cnt;
                        r_pass     <= (r_cnt == r_exp);
                    end else if (r_cnt == TMO) begin
                        r_measured <= TMO;
                        r_pass     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign chain_din = r_chain_din;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_REPORT);
    assign pass      = r_pass;
    assign stuck     = r_stuck;
    assign measured  = r_measured;

endmodule

// File: tb/tb_chain_test_ctrl.sv
// Bench for chain_test_ctrl: behavioural delay chains driven by the DUT,
// a vector table of chain scenarios, and hand sequences for reset/bypass/busy.
module tb_chain_test_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [2:0] chain_sel;
    logic [7:0] expected, user_din, chain_dout, chain_din, measured;
    logic       busy, done, pass, stuck;

    always #5 clk = ~clk;

    chain_test_ctrl #(.N(80), .FLUSH_CYC(96), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .chain_sel(chain_sel),
        .expected(expected), .user_din(user_din), .chain_dout(chain_dout),
        .chain_din(chain_din), .busy(busy), .done(done), .pass(pass),
        .stuck(stuck), .measured(measured)
    );

    // chain models: mode 0 = shift register of given depth, 1 = tied 0, 2 = tied 1
    logic [254:0] sh [8];
    int           depth [8] = '{80, 80, 80, 80, 80, 80, 80, 80};
    int           mode  [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic         chain_clr;

    always @(posedge clk)
        for (int i = 0; i < 8; i++)
            sh[i] <= chain_clr ? '0 : {sh[i][253:0], chain_din[i]};

    always_comb begin
        chain_dout = '0;
        for (int i = 0; i < 8; i++)
            chain_dout[i] = (mode[i] == 1) ? 1'b0 : (mode[i] == 2) ? 1'b1 : sh[i][depth[i]-1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pulse_cnt = 0, done_cnt = 0, pulse_cyc = 0, done_cyc = 0;
    logic [7:0] pulse_val, d_meas;
    logic       d_pass, d_stuck;
    always @(negedge clk) begin
        if (busy && chain_din != 8'h00) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_val = chain_din;
            pulse_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            d_meas   = measured;
            d_pass   = pass;
            d_stuck  = stuck;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] expv;
        int         dep;
        int         md;
        bit         others_hi;
        logic [7:0] meas;
        bit         pas;
        bit         stk;
        int         dly;   // cycles from start cycle to done cycle
    } vec_t;

    vec_t vecs [8];

    task automatic wait_done(input int base, input int budget, input string name);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " done_seen"}, done_cnt != base, 1);
    endtask

    task automatic setup_chains(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            depth[i] = 80;
            mode[i]  = v.others_hi ? 2 : 0;
        end
        depth[v.sel] = v.dep;
        mode[v.sel]  = v.md;
        chain_clr    = 1'b1;
        @(negedge clk);
        chain_clr    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         p_base, d_base, s_cyc;
        logic [7:0] oh;
        oh = 8'h01 << v.sel;
        @(negedge clk);
        user_din = 8'h00;
        setup_chains(v);
        p_base    = pulse_cnt;
        d_base    = done_cnt;
        chain_sel = v.sel;
        expected  = v.expv;
        start     = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        start     = 1'b0;
        chain_sel = 3'd0;
        expected  = 8'h00;
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " cleared_on_start"}, {pass, stuck, measured}, 0);
        wait_done(d_base, 600, tag);
        check({tag, " measured"}, d_meas, v.meas);
        check({tag, " pass"}, d_pass, v.pas);
        check({tag, " stuck"}, d_stuck, v.stk);
        check({tag, " done_delay"}, done_cyc - s_cyc, v.dly);
        check({tag, " pulse_count"}, pulse_cnt - p_base, v.stk ? 0 : 1);
        if (!v.stk) check({tag, " pulse_onehot"}, pulse_val, oh);
        repeat (3) @(negedge clk);
        check({tag, " single_done"}, done_cnt - d_base, 1);
        check({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_base, k;
        vecs[0] = '{3'd3, 8'd80,  80,  0, 1'b0, 8'd80,  1'b1, 1'b0, 178};
        vecs[1] = '{3'd5, 8'd80,  79,  0, 1'b0, 8'd79,  1'b0, 1'b0, 177};
        vecs[2] = '{3'd2, 8'd80,  80,  1, 1'b0, 8'd255, 1'b0, 1'b0, 353};
        vecs[3] = '{3'd6, 8'd80,  80,  2, 1'b0, 8'd0,   1'b0, 1'b1, 97};
        vecs[4] = '{3'd0, 8'd1,   1,   0, 1'b0, 8'd1,   1'b1, 1'b0, 99};
        vecs[5] = '{3'd7, 8'd255, 255, 0, 1'b0, 8'd255, 1'b1, 1'b0, 353};
        vecs[6] = '{3'd1, 8'd10,  10,  0, 1'b1, 8'd10,  1'b1, 1'b0, 108};
        vecs[7] = '{3'd4, 8'd50,  60,  0, 1'b0, 8'd60,  1'b0, 1'b0, 158};

        rst = 1'b1; start = 1'b0; chain_sel = 3'd0; expected = 8'h00;
        user_din = 8'hFF; chain_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("reset chain_din", chain_din, 0);
        check("reset busy", busy, 0);
        check("reset flags", {done, pass, stuck}, 0);
        check("reset measured", measured, 0);
        start = 1'b1; chain_sel = 3'd3;
        @(negedge clk);
        check("reset_over_start busy", busy, 0);
        rst = 1'b0; start = 1'b0; chain_clr = 1'b0; user_din = 8'h00;

        // bypass
        @(negedge clk);
        user_din = 8'hA5;
        @(negedge clk);
        check("bypass A5", chain_din, 8'hA5);
        user_din = 8'h3C;
        @(negedge clk);
        check("bypass 3C", chain_din, 8'h3C);
        user_din = 8'h00;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of MEASURE at count 40
        setup_chains(vecs[0]);
        d_base = done_cnt;
        k = pulse_cnt;
        chain_sel = 3'd3; expected = 8'd80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 200 && pulse_cnt == k; j++) @(negedge clk);
        check("midrst pulse_seen", pulse_cnt - k, 1);
        for (int j = 0; j < 100 && cyc < pulse_cyc + 40; j++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst chain_din", chain_din, 0);
        repeat (150) @(negedge clk);
        check("midrst no_done", done_cnt - d_base, 0);
        run_vec(vecs[0], "after_rst");

        // starts while busy are ignored; results held afterwards
        setup_chains(vecs[0]);
        d_base = done_cnt;
        chain_sel = 3'd3; expected = 8'd80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chain_sel = 3'd2; expected = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (110) @(negedge clk);
        chain_sel = 3'd6; expected = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d_base, 300, "busy_ign");
        check("busy_ign measured", d_meas, 80);
        check("busy_ign pass", d_pass, 1);
        repeat (20) @(negedge clk);
        check("busy_ign one_done", done_cnt - d_base, 1);
        check("held pass", pass, 1);
        check("held measured", measured, 80);
        check("held busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
